// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: shares one synchronous-read RAM between scanout reads
// (strict priority) and draw-engine writes, with a starvation flag for the draw side.
module fb_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 3,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              drw_req,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_data,
    output logic              drw_ack,
    output logic              drw_starved,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic              vga_valid_q, vga_valid_d;
    logic              rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              starved_q, starved_d;
    logic              drw_elig_s;
    logic              wr_grant_s;

    // Write and ack are both exactly "state is WR"; no extra decode logic.
    assign mem_we      = (state_q == WR);
    assign drw_ack     = (state_q == WR);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign vga_data    = vga_data_q;
    assign vga_valid   = vga_valid_q;
    assign drw_starved = starved_q;

    // A draw request seen on its own ack cycle is the tail of the finished write.
    assign drw_elig_s = drw_req & ~drw_ack;

    // Grant selection, memory command, read capture and starvation counting.
    always_comb begin
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_pend_d   = 1'b0;
        wr_grant_s  = 1'b0;
        vga_valid_d = rd_pend_q;
        vga_data_d  = vga_data_q;
        wait_cnt_d  = wait_cnt_q;

        if (rd_pend_q) begin
            vga_data_d = mem_rdata;
        end else begin
            vga_data_d = vga_data_q;
        end

        case (state_q)
            IDLE, RD, WR: begin
                if (vga_req) begin
                    state_d    = RD;
                    mem_addr_d = vga_addr;
                    rd_pend_d  = 1'b1;
                end else if (drw_elig_s) begin
                    state_d     = WR;
                    mem_addr_d  = drw_addr;
                    mem_wdata_d = drw_data;
                    wr_grant_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!drw_req || drw_ack || wr_grant_s) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < LIMIT_C) begin
            wait_cnt_d = wait_cnt_q + ONE_C;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        starved_d = (wait_cnt_d == LIMIT_C);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vga_data_q  <= '0;
            vga_valid_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            wait_cnt_q  <= '0;
            starved_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vga_data_q  <= vga_data_d;
            vga_valid_q <= vga_valid_d;
            rd_pend_q   <= rd_pend_d;
            wait_cnt_q  <= wait_cnt_d;
            starved_q   <= starved_d;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural frame-buffer RAM model.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [2:0]  vga_data;
    logic        vga_valid;
    logic        drw_req;
    logic [15:0] drw_addr;
    logic [2:0]  drw_data;
    logic        drw_ack;
    logic        drw_starved;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;

    logic [2:0]  ram [65536];
    logic        pl_we;
    logic [15:0] pl_addr;
    logic [2:0]  pl_data;
    int          wr_cnt;
    int          n_cmp;
    int          n_bad;

    fb_arbiter #(.ADDR_W(16), .DATA_W(3), .STARVE_LIMIT(64)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .drw_req(drw_req), .drw_addr(drw_addr), .drw_data(drw_data),
        .drw_ack(drw_ack), .drw_starved(drw_starved),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM registers the address externally (mem_addr), so data follows it within the cycle.
    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end else if (pl_we) begin
            ram[pl_addr] <= pl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [2:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},   32'(vga_valid),   32'd0);
        chk({tag, "_vdata"},   32'(vga_data),    32'd0);
        chk({tag, "_ack"},     32'(drw_ack),     32'd0);
        chk({tag, "_starved"}, 32'(drw_starved), 32'd0);
        chk({tag, "_we"},      32'(mem_we),      32'd0);
        chk({tag, "_maddr"},   32'(mem_addr),    32'd0);
        chk({tag, "_wdata"},   32'(mem_wdata),   32'd0);
    endtask

    task automatic single_read(input string tag);
        vga_req  = 1'b1;
        vga_addr = 16'h0123;
        tick();
        vga_req = 1'b0;
        chk({tag, "_maddr"}, 32'(mem_addr),  32'h0123);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_v1"},    32'(vga_valid), 32'd0);
        tick();
        chk({tag, "_v2"},    32'(vga_valid), 32'd1);
        chk({tag, "_data"},  32'(vga_data),  32'd5);
        tick();
        chk({tag, "_v3"},    32'(vga_valid), 32'd0);
        chk({tag, "_hold"},  32'(vga_data),  32'd5);
    endtask

    logic [2:0] exp8 [8];
    int         wr0;

    initial begin
        exp8 = '{3'd6, 3'd1, 3'd7, 3'd0, 3'd3, 3'd5, 3'd2, 3'd4};
        n_cmp = 0; n_bad = 0; wr_cnt = 0;
        pl_we = 1'b0; pl_addr = 16'h0; pl_data = 3'd0;
        reset = 1'b1; vga_req = 1'b0; vga_addr = 16'h0;
        drw_req = 1'b0; drw_addr = 16'h0; drw_data = 3'd0;
        tick();
        tick();
        check_reset_outputs("rst");

        // Preload runs under reset so the DUT stays idle.
        preload(16'h0123, 3'b101);
        preload(16'h0010, 3'd3);
        preload(16'h0011, 3'd6);
        preload(16'h0012, 3'd1);
        for (int i = 0; i < 8; i++) preload(16'(i), exp8[i]);
        reset = 1'b0;
        tick();

        single_read("rd1");

        // Single write, request dropped one cycle late.
        wr0 = wr_cnt;
        drw_req = 1'b1; drw_addr = 16'h0040; drw_data = 3'b010;
        tick();
        chk("wr_we",    32'(mem_we),    32'd1);
        chk("wr_ack",   32'(drw_ack),   32'd1);
        chk("wr_addr",  32'(mem_addr),  32'h0040);
        chk("wr_wdata", 32'(mem_wdata), 32'd2);
        tick();
        drw_req = 1'b0;
        chk("wr_we2",   32'(mem_we),    32'd0);
        chk("wr_ack2",  32'(drw_ack),   32'd0);
        chk("wr_hold",  32'(mem_addr),  32'h0040);
        tick();
        chk("wr_once",  32'(wr_cnt - wr0), 32'd1);
        chk("wr_ram",   32'(ram[16'h0040]), 32'd2);

        // Collision: three reads win, write follows on the fourth cycle.
        vga_req = 1'b1; vga_addr = 16'h0010;
        drw_req = 1'b1; drw_addr = 16'h0080; drw_data = 3'd7;
        tick();
        chk("col1_we",  32'(mem_we),   32'd0);
        chk("col1_ack", 32'(drw_ack),  32'd0);
        vga_addr = 16'h0011;
        tick();
        chk("col2_v",   32'(vga_valid), 32'd1);
        chk("col2_d",   32'(vga_data),  32'd3);
        chk("col2_ack", 32'(drw_ack),   32'd0);
        vga_addr = 16'h0012;
        tick();
        chk("col3_v",   32'(vga_valid), 32'd1);
        chk("col3_d",   32'(vga_data),  32'd6);
        chk("col3_ack", 32'(drw_ack),   32'd0);
        vga_req = 1'b0;
        tick();
        chk("col4_ack", 32'(drw_ack),   32'd1);
        chk("col4_we",  32'(mem_we),    32'd1);
        chk("col4_adr", 32'(mem_addr),  32'h0080);
        chk("col4_v",   32'(vga_valid), 32'd1);
        chk("col4_d",   32'(vga_data),  32'd1);
        drw_req = 1'b0;
        tick();
        chk("col5_v",   32'(vga_valid), 32'd0);
        chk("col5_ack", 32'(drw_ack),   32'd0);

        // Starvation: reads hold the port for 70 cycles.
        vga_req = 1'b1; vga_addr = 16'h0000;
        drw_req = 1'b1; drw_addr = 16'h0099; drw_data = 3'd4;
        for (int i = 1; i <= 70; i++) begin
            tick();
            chk($sformatf("stv_flag%0d", i), 32'(drw_starved), (i >= 64) ? 32'd1 : 32'd0);
            chk($sformatf("stv_ack%0d", i),  32'(drw_ack),     32'd0);
        end
        vga_req = 1'b0;
        tick();
        chk("stv_wr_ack", 32'(drw_ack),     32'd1);
        chk("stv_wr_we",  32'(mem_we),      32'd1);
        chk("stv_wr_adr", 32'(mem_addr),    32'h0099);
        chk("stv_clr",    32'(drw_starved), 32'd0);
        drw_req = 1'b0;
        tick();
        chk("stv_ack_end", 32'(drw_ack),     32'd0);
        chk("stv_clr2",    32'(drw_starved), 32'd0);

        // Reset one cycle after a read request discards it.
        vga_req = 1'b1; vga_addr = 16'h0123;
        tick();
        vga_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("rmid");
        tick();
        chk("rmid_nov", 32'(vga_valid), 32'd0);
        single_read("rd2");

        // A draw request held through reset is granted on the first edge after it.
        drw_req = 1'b1; drw_addr = 16'h0055; drw_data = 3'd3; reset = 1'b1;
        tick();
        chk("rdw_ack0", 32'(drw_ack), 32'd0);
        chk("rdw_we0",  32'(mem_we),  32'd0);
        reset = 1'b0;
        tick();
        chk("rdw_ack1", 32'(drw_ack),  32'd1);
        chk("rdw_addr", 32'(mem_addr), 32'h0055);
        drw_req = 1'b0;
        tick();

        // Back-to-back reads of addresses 0..7.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                vga_req  = 1'b1;
                vga_addr = 16'(i);
            end else begin
                vga_req = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 8) begin
                chk($sformatf("b2b_v%0d", i - 1), 32'(vga_valid), 32'd1);
                chk($sformatf("b2b_d%0d", i - 1), 32'(vga_data),  32'(exp8[i-1]));
            end else if (i == 9) begin
                chk("b2b_vend", 32'(vga_valid), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
